uart_rx_sipo: RTL and testbench

Serial-in/parallel-out UART receiver, the receive-side counterpart of the transmitter's PISO unit. It accepts the same 11-bit frame: start (0), 8 data bits LSB first, parity, stop (1). The line is oversampled on a tick clock from the BaudGen unit. Each received byte is presented in parallel with a one-cycle valid pulse and parity/framing status.

---
 rtl/uart_rx_sipo.sv | 134 +++++++++++++
 tb/tb_uart_rx_sipo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sipo.sv
// UART serial-in/parallel-out receiver: start, 8 data bits LSB first, parity, stop.
// The line is oversampled by OVERSAMPLE baud_clk ticks per bit and sampled mid-bit.
module uart_rx_sipo #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_END = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          p_rx_q, p_rx_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            p_rx_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= data_rx;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            p_rx_q  <= p_rx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        p_rx_d  = p_rx_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // Mid-start-bit recheck rejects glitches shorter than half a bit
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (cnt_q == FULL_END) begin
                    cnt_d   = '0;
                    p_rx_d  = rx_s_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_END) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    perr_d  = p_rx_q ^ (^shift_q) ^ PARITY_ODD;
                    ferr_d  = ~rx_s_q;
                    valid_d = 1'b1;
                    state_d = rx_s_q ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // A held-low break must go high before another start is accepted
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        active_flag = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);
        done_flag   = ~active_flag;
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo at OVERSAMPLE=16, even parity.
module tb_uart_rx_sipo;

    logic       baud_clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, parity_error, framing_error, active_flag, done_flag;

    uart_rx_sipo #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
        .baud_clk(baud_clk), .rst(rst), .data_rx(data_rx),
        .data_out(data_out), .data_valid(data_valid),
        .parity_error(parity_error), .framing_error(framing_error),
        .active_flag(active_flag), .done_flag(done_flag)
    );

    always #5 baud_clk = ~baud_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge baud_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // data_valid monitor, sampled on the falling edge
    int         dv_cnt = 0;
    int         dv_cyc [16];
    logic [7:0] dv_dat [16];
    logic       dv_pe  [16];
    logic       dv_fe  [16];
    logic       dv_act_before [16];
    logic       dv_act_at [16];
    logic       act_prev = 1'b0;

    always @(negedge baud_clk) begin
        if (data_valid && dv_cnt < 16) begin
            dv_cyc[dv_cnt]        = cyc;
            dv_dat[dv_cnt]        = data_out;
            dv_pe[dv_cnt]         = parity_error;
            dv_fe[dv_cnt]         = framing_error;
            dv_act_before[dv_cnt] = act_prev;
            dv_act_at[dv_cnt]     = active_flag;
        end
        if (data_valid) dv_cnt++;
        act_prev = active_flag;
    end

    task automatic drive_bit(input logic b, input int n);
        data_rx = b;
        repeat (n) @(negedge baud_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              output int fall);
        fall = cyc;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        drive_bit(p, 16);
        drive_bit(stp, 16);
    endtask

    int f0, f1, base, hi_seen, act_bad, act_e10;
    logic [7:0] snap_d;
    logic       snap_pe, snap_fe;

    initial begin
        // reset state
        repeat (3) @(negedge baud_clk);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_perr", 32'(parity_error), 0);
        chk("rst_ferr", 32'(framing_error), 0);
        chk("rst_active", 32'(active_flag), 0);
        chk("rst_done", 32'(done_flag), 1);
        rst = 1'b0;
        repeat (4) @(negedge baud_clk);

        // 0xA5, correct even parity 0
        base = dv_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, f0);
        drive_bit(1'b1, 20);
        chk("a5_count", 32'(dv_cnt - base), 1);
        chk("a5_latency", 32'(dv_cyc[base] - f0), 171);
        chk("a5_data", 32'(dv_dat[base]), 32'hA5);
        chk("a5_perr", 32'(dv_pe[base]), 0);
        chk("a5_ferr", 32'(dv_fe[base]), 0);
        chk("a5_act_before", 32'(dv_act_before[base]), 1);
        chk("a5_act_fall", 32'(dv_act_at[base]), 0);
        chk("a5_done_idle", 32'(done_flag), 1);

        // 0x01 with parity 0 -> parity error
        base = dv_cnt;
        send_frame(8'h01, 1'b0, 1'b1, f0);
        drive_bit(1'b1, 20);
        chk("p01_count", 32'(dv_cnt - base), 1);
        chk("p01_data", 32'(dv_dat[base]), 32'h01);
        chk("p01_perr", 32'(dv_pe[base]), 1);
        chk("p01_ferr", 32'(dv_fe[base]), 0);

        // 0x3C, stop bit 0, line held low 40 more cycles
        base = dv_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, f0);
        act_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (active_flag) act_bad++;
            @(negedge baud_clk);
        end
        drive_bit(1'b1, 200);
        chk("brk_count", 32'(dv_cnt - base), 1);
        chk("brk_data", 32'(dv_dat[base]), 32'h3C);
        chk("brk_ferr", 32'(dv_fe[base]), 1);
        chk("brk_perr", 32'(dv_pe[base]), 0);
        chk("brk_wait_active", 32'(act_bad), 0);

        // 4-cycle glitch -> false start
        base = dv_cnt;
        snap_d = data_out; snap_pe = parity_error; snap_fe = framing_error;
        f0 = cyc;
        hi_seen = 0;
        act_e10 = 1;
        data_rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) data_rx = 1'b1;
            @(negedge baud_clk);
            if (active_flag) hi_seen = 1;
            if (cyc == f0 + 11) act_e10 = int'(active_flag);
        end
        chk("glitch_act_pulse", 32'(hi_seen), 1);
        chk("glitch_act_e10", 32'(act_e10), 0);
        chk("glitch_count", 32'(dv_cnt - base), 0);
        chk("glitch_data", 32'(data_out), 32'(snap_d));
        chk("glitch_flags", 32'({parity_error, framing_error}), 32'({snap_pe, snap_fe}));

        // back-to-back 0x00 then 0xFF
        base = dv_cnt;
        send_frame(8'h00, 1'b0, 1'b1, f0);
        send_frame(8'hFF, 1'b0, 1'b1, f1);
        drive_bit(1'b1, 20);
        chk("b2b_count", 32'(dv_cnt - base), 2);
        chk("b2b_gap", 32'(dv_cyc[base+1] - dv_cyc[base]), 176);
        chk("b2b_data0", 32'(dv_dat[base]), 32'h00);
        chk("b2b_data1", 32'(dv_dat[base+1]), 32'hFF);
        chk("b2b_err0", 32'({dv_pe[base], dv_fe[base]}), 0);
        chk("b2b_err1", 32'({dv_pe[base+1], dv_fe[base+1]}), 0);

        // reset during data bit 3 of 0xC3, then 0x5A
        base = dv_cnt;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 8);
        rst = 1'b1;
        @(negedge baud_clk);
        chk("mrst_data", 32'(data_out), 0);
        chk("mrst_flags", 32'({data_valid, parity_error, framing_error}), 0);
        chk("mrst_active", 32'({active_flag, done_flag}), 32'b01);
        repeat (2) @(negedge baud_clk);
        rst = 1'b0;
        drive_bit(1'b1, 40);
        chk("mrst_no_pulse", 32'(dv_cnt - base), 0);
        send_frame(8'h5A, 1'b0, 1'b1, f0);
        drive_bit(1'b1, 20);
        chk("post_count", 32'(dv_cnt - base), 1);
        chk("post_latency", 32'(dv_cyc[base] - f0), 171);
        chk("post_data", 32'(dv_dat[base]), 32'h5A);
        chk("post_err", 32'({dv_pe[base], dv_fe[base]}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
